// File: rtl/cnn_layer_sequencer_if.sv
// Host and engine handshake bundle for the CNN layer sequencer.
// The master modport is the sequencer side; the slave modport is the host and engines.
interface cnn_layer_sequencer_if #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned CNT_W    = 32
);
  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic                start;
  logic                abort;
  logic [N_STAGES-1:0] stage_start;
  logic [N_STAGES-1:0] stage_done;
  logic                busy;
  logic                done;
  logic                error;
  logic [SW-1:0]       err_stage;
  logic [SW-1:0]       cur_stage;
  logic [CNT_W-1:0]    cycle_count;

  modport master (
    input  start, abort, stage_done,
    output stage_start, busy, done, error, err_stage, cur_stage, cycle_count
  );

  modport slave (
    output start, abort, stage_done,
    input  stage_start, busy, done, error, err_stage, cur_stage, cycle_count
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Runs N_STAGES layer engines strictly in order via start/done handshakes, with a per-stage
// watchdog, an abort path and a saturating run-latency counter. All outputs are registered.
module cnn_layer_sequencer #(
  parameter int unsigned N_STAGES       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cnn_layer_sequencer_if.master bus
);
  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       cur_q, cur_d;
  logic [SW-1:0]       err_stage_q, err_stage_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         wd_q, wd_d;
  logic [N_STAGES-1:0] stage_start_q, stage_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cur_done, last_stage, timeout;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    err_stage_d = err_stage_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;

    cur_done   = bus.stage_done[cur_q];
    last_stage = (32'(cur_q) == N_STAGES - 1);
    timeout    = (TIMEOUT_CYCLES != 0) && (wd_q == TIMEOUT_CYCLES - 1);

    if (state_q != StIdle && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StIssue;
          cur_d       = '0;
          error_d     = 1'b0;
          err_stage_d = '0;
          cnt_d       = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        wd_d    = '0;
      end
      StWait: begin
        // Done is checked before the watchdog so a same-cycle done still advances.
        if (cur_done) begin
          if (last_stage) begin
            state_d = StFinish;
          end else begin
            state_d = StIssue;
            cur_d   = cur_q + SW'(1);
          end
        end else if (timeout) begin
          state_d     = StIdle;
          error_d     = 1'b1;
          err_stage_d = cur_q;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Abort wins over done and timeout: no stage advance, error flags untouched.
    if (bus.abort && state_q != StIdle) begin
      state_d     = StIdle;
      cur_d       = cur_q;
      error_d     = error_q;
      err_stage_d = err_stage_q;
    end

    stage_start_d = '0;
    if (state_d == StIssue) begin
      stage_start_d = N_STAGES'(1) << cur_d;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      err_stage_q   <= '0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
      wd_q          <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      err_stage_q   <= err_stage_d;
      error_q       <= error_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.stage_start = stage_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.err_stage   = err_stage_q;
  assign bus.cur_stage   = cur_q;
  assign bus.cycle_count = cnt_q;
endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level scheduler for the CNN inference pipeline. It runs the layer engines (conv, maxpool, dense, ...) strictly in order through their `start`/`done` handshakes. Each stage runs only after the previous stage's output buffer is complete. A per-stage watchdog, an abort path and a total-latency counter let the host detect a hung engine and profile a run.

## Interface
Parameters:
- `N_STAGES`, default 3: number of engines sequenced; index 0 runs first.
- `TIMEOUT_CYCLES`, default 100000: maximum WAIT cycles per stage. 0 disables the watchdog.
- `CNT_W`, default 32: width of `cycle_count`.

Local parameter:
- `SW` = max(1, $clog2(N_STAGES)).

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: run request, sampled only in IDLE.
- `abort`, in, 1: cancels a run in progress.
- `stage_start`, out, N_STAGES: one-hot, 1-cycle start pulse to engine i.
- `stage_done`, in, N_STAGES: completion indication from engine i; may be a pulse or a level.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: 1-cycle pulse when the last stage completes.
- `error`, out, 1: sticky watchdog-timeout flag.
- `err_stage`, out, SW: index of the stage that timed out.
- `cur_stage`, out, SW: index of the stage currently issued or awaited.
- `cycle_count`, out, CNT_W: latency of the current or last run.

## Operation
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- **IDLE**
  - `start`=1 → ISSUE, with `cur_stage`=0, `error`=0, `err_stage`=0 and `cycle_count`=0.
  - `abort` is ignored in IDLE.
- **ISSUE** (exactly one cycle)
  - `stage_start[cur_stage]`=1; all other bits are 0.
  - Next state is WAIT; the watchdog counter is cleared.
  - `stage_done` is not sampled in ISSUE.
- **WAIT**
  - `stage_done[cur_stage]`=1 with `cur_stage` < N_STAGES-1 → ISSUE, `cur_stage`+1.
  - `stage_done[cur_stage]`=1 with `cur_stage` = N_STAGES-1 → FINISH.
  - Otherwise the watchdog counter increments. After TIMEOUT_CYCLES WAIT cycles with no done (and TIMEOUT_CYCLES ≠ 0) → IDLE, with `error`=1 and `err_stage`=`cur_stage`. No `done` pulse is produced.
- **FINISH** (exactly one cycle): `done`=1, then → IDLE.
- Done inputs of stages other than `cur_stage` are ignored.
- Requirement on engines: a level-style done must deassert by the cycle after its start pulse.
- **Abort:** `abort`=1 in ISSUE, WAIT or FINISH → IDLE next cycle.
  - No `done` pulse.
  - `error` is unchanged.
  - Any `stage_start` pulse already emitted is not retracted.
- **Abort precedence:** abort beats stage done and timeout. Done beats timeout when both occur in the same WAIT cycle.
- **`start` while busy** is ignored; it is not queued.
- **`cycle_count`**
  - Increments in every ISSUE, WAIT and FINISH cycle; counts from 1 in the first ISSUE.
  - Saturates at 2^CNT_W−1.
  - Holds its value in IDLE until the next accepted `start`.
- **`cur_stage`, `err_stage`, `error`** hold their values in IDLE.

## Timing
- All outputs are registered.
- Reset values: `stage_start`=0, `busy`=0, `done`=0, `error`=0, `err_stage`=0, `cur_stage`=0, `cycle_count`=0, state = IDLE.
- `reset` mid-run → IDLE on the next edge with every output at its reset value; `start` in the same cycle is ignored.
- Cycle labels: `start` sampled at edge 0.
  - `busy` and `stage_start[0]` are high in cycle 1.
  - WAIT begins in cycle 2.
- Stage handoff: done sampled in cycle d → next `stage_start` in cycle d+1. The handoff overhead is 1 cycle per stage.
- Last done sampled in cycle d → `done`=1 in cycle d+1, `busy`=0 from cycle d+2.
- A new `start` is accepted in the first IDLE cycle after FINISH, so back-to-back runs are possible.

## Test plan
- **Normal run.** N_STAGES=3; engine models assert done 5, 10 and 3 cycles after their start pulse; `start` at cycle 0. Expect:
  - `stage_start` bits in cycles 1, 7 and 18;
  - `done` in cycle 22;
  - `cycle_count`=22;
  - `busy` high in cycles 1–22;
  - `error`=0.
- **Watchdog timeout.** TIMEOUT_CYCLES=20; stage 1 never responds. Expect `error`=1, `err_stage`=1, `busy`=0 exactly 20 WAIT cycles after stage 1 enters WAIT, no `done` pulse, and no `stage_start[2]`. A following `start` clears `error` and the run completes normally.
- **Abort mid-run.** `abort` during stage 1 WAIT → `busy`=0 the next cycle, no `done`, `error`=0. The late `stage_done[1]` that arrives afterwards is ignored while IDLE.
- **Spurious and ignored inputs.**
  - `stage_done[2]` pulsed during stage 0 WAIT → ignored; the sequence still runs 0, 1, 2.
  - `start` re-asserted mid-run → no restart, single `done`.
  - `stage_done[0]` high during the ISSUE cycle → not taken.
- **Reset mid-run.** Synchronous `reset` in stage 2 WAIT → all outputs 0 next edge. A subsequent `start` produces a complete run with `cycle_count` restarting at 1.
- **Precedence and saturation.**
  - done and timeout in the same WAIT cycle → advances with no error.
  - abort and done in the same cycle → IDLE with no `done`.
  - CNT_W=4 with a 20-cycle run → `cycle_count`=15.
